// File: rtl/scp_079.sv
// ---------------------------------------------------------------------------
// scp_079 -- containment-monitor FSM.
//
// Once per clock the block samples a one-hot condition (green/yellow/red).
// From that it tracks six phases: nominal, attack, two levels of escalating
// trouble, lockdown and recovery. It reports the phase code, how long it has
// been in that phase, three alarm levels and a flag for a malformed input.
//
// Ports
//   i_clock      in   1  system clock, rising-edge active
//   i_reset_n    in   1  asynchronous, active-low reset
//   i_green      in   1  condition nominal
//   i_yellow     in   1  condition degraded
//   i_red        in   1  condition critical
//   o_state      out  3  current state code (OK=0 .. RECOVER=5)
//   o_timer      out  6  cycles in current state (LOCKDOWN: consecutive greens)
//   o_a1         out  1  alarm level 1 (TROUBLE_A1, TROUBLE_A2, LOCKDOWN)
//   o_a2         out  1  alarm level 2 (TROUBLE_A2, LOCKDOWN)
//   o_a3         out  1  alarm level 3 (LOCKDOWN)
//   o_cheat_out  out  1  invalid condition sampled on the last edge
// ---------------------------------------------------------------------------
module scp_079 #(
  parameter int T_OK     = 20,
  parameter int T_ATTACK = 10,
  parameter int T_A1     = 30,
  parameter int T_A2     = 60,
  parameter int T_LOCK   = 10,
  parameter int T_REC    = 5
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_green,
  input  logic       i_yellow,
  input  logic       i_red,
  output logic [2:0] o_state,
  output logic [5:0] o_timer,
  output logic       o_a1,
  output logic       o_a2,
  output logic       o_a3,
  output logic       o_cheat_out
);

  localparam logic [2:0] S_OK     = 3'd0;
  localparam logic [2:0] S_ATTACK = 3'd1;
  localparam logic [2:0] S_A1     = 3'd2;
  localparam logic [2:0] S_A2     = 3'd3;
  localparam logic [2:0] S_LOCK   = 3'd4;
  localparam logic [2:0] S_REC    = 3'd5;

  // Timer values on which the leaving transition fires (T-1, all T in 1..64).
  localparam logic [5:0] L_OK     = 6'(T_OK - 1);
  localparam logic [5:0] L_ATTACK = 6'(T_ATTACK - 1);
  localparam logic [5:0] L_A1     = 6'(T_A1 - 1);
  localparam logic [5:0] L_A2     = 6'(T_A2 - 1);
  localparam logic [5:0] L_LOCK   = 6'(T_LOCK - 1);
  localparam logic [5:0] L_REC    = 6'(T_REC - 1);

  logic [2:0] r_state;
  logic [5:0] r_timer;
  logic       r_cheat;
  logic [2:0] w_state_next;
  logic [5:0] w_timer_next;
  logic       w_valid;

  // Exactly one condition line high; anything else freezes the FSM.
  assign w_valid = ({i_green, i_yellow, i_red} == 3'b100) ||
                   ({i_green, i_yellow, i_red} == 3'b010) ||
                   ({i_green, i_yellow, i_red} == 3'b001);

  // State register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_OK;
      r_timer <= 6'd0;
      r_cheat <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_timer <= w_timer_next;
      r_cheat <= !w_valid;
    end
  end

  // Next-state and timer logic.
  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    if (r_state > S_REC) begin
      // Unused codes recover unconditionally, even on an invalid sample.
      w_state_next = S_OK;
      w_timer_next = 6'd0;
    end else if (w_valid) begin
      // With a valid sample, "not red and not yellow" means green.
      case (r_state)
        S_OK: begin
          if (i_red)                  w_state_next = S_LOCK;
          else if (i_yellow)          w_state_next = S_A1;
          else if (r_timer == L_OK)   w_state_next = S_ATTACK;
        end
        S_ATTACK: begin
          if (i_red)                    w_state_next = S_LOCK;
          else if (i_yellow)            w_state_next = S_A1;
          else if (r_timer == L_ATTACK) w_state_next = S_OK;
        end
        S_A1: begin
          if (i_red)                  w_state_next = S_LOCK;
          else if (i_green)           w_state_next = S_REC;
          else if (r_timer == L_A1)   w_state_next = S_A2;
        end
        S_A2: begin
          if (i_red)                  w_state_next = S_LOCK;
          else if (i_green)           w_state_next = S_REC;
          else if (r_timer == L_A2)   w_state_next = S_LOCK;
        end
        S_LOCK: begin
          if (i_green && (r_timer == L_LOCK)) w_state_next = S_REC;
        end
        S_REC: begin
          if (i_red)                  w_state_next = S_LOCK;
          else if (i_yellow)          w_state_next = S_A1;
          else if (r_timer == L_REC)  w_state_next = S_OK;
        end
        default: w_state_next = S_OK;
      endcase

      if (w_state_next != r_state)
        w_timer_next = 6'd0;
      else if ((r_state == S_LOCK) && !i_green)
        w_timer_next = 6'd0;          // lockdown counts consecutive greens only
      else if (r_timer != 6'd63)
        w_timer_next = r_timer + 6'd1;
    end
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    o_a1 = 1'b0;
    o_a2 = 1'b0;
    o_a3 = 1'b0;
    case (r_state)
      S_A1:    o_a1 = 1'b1;
      S_A2:    begin o_a1 = 1'b1; o_a2 = 1'b1; end
      S_LOCK:  begin o_a1 = 1'b1; o_a2 = 1'b1; o_a3 = 1'b1; end
      default: ;
    endcase
  end

  assign o_state     = r_state;
  assign o_timer     = r_timer;
  assign o_cheat_out = r_cheat;

endmodule

// File: tb/tb_scp_079.sv
// ---------------------------------------------------------------------------
// tb_scp_079 -- directed bench for scp_079.
// Each step drives one input sample. A behavioural model predicts the
// registered state/timer/cheat/alarms after the next edge. The prediction is
// queued and is then popped and compared once the edge has happened.
// ---------------------------------------------------------------------------
module tb_scp_079;

  logic       clk;
  logic       rst_n;
  logic       g, y, r;
  logic [2:0] state;
  logic [5:0] timer;
  logic       a1, a2, a3, cheat;

  scp_079 dut (
    .i_clock    (clk),
    .i_reset_n  (rst_n),
    .i_green    (g),
    .i_yellow   (y),
    .i_red      (r),
    .o_state    (state),
    .o_timer    (timer),
    .o_a1       (a1),
    .o_a2       (a2),
    .o_a3       (a3),
    .o_cheat_out(cheat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int st;
    int tm;
    int ch;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   edge_no = 0;

  // Model state.
  int m_st = 0;
  int m_tm = 0;
  int m_ch = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  function automatic int alarms_of(input int st);
    case (st)
      2: return 1;
      3: return 3;
      4: return 7;
      default: return 0;
    endcase
  endfunction

  // Behavioural prediction of one edge with condition lines gi/yi/ri.
  task automatic model_edge(input bit gi, input bit yi, input bit ri);
    int nxt;
    int last;
    if (gi + yi + ri != 1) begin
      m_ch = 1;
      return;
    end
    m_ch = 0;
    nxt  = m_st;
    case (m_st)
      0: last = 19;
      1: last = 9;
      2: last = 29;
      3: last = 59;
      4: last = 9;
      default: last = 4;
    endcase
    if (m_st == 4) begin
      if (gi && m_tm == last) nxt = 5;
    end else if (ri) begin
      nxt = 4;
    end else if (m_st == 2 || m_st == 3) begin
      if (gi) nxt = 5;
      else if (m_tm == last) nxt = (m_st == 2) ? 3 : 4;
    end else begin
      if (yi) nxt = 2;
      else if (m_tm == last) nxt = (m_st == 0) ? 1 : 0;
    end
    if (nxt != m_st)          m_tm = 0;
    else if (m_st == 4 && !gi) m_tm = 0;
    else if (m_tm < 63)       m_tm = m_tm + 1;
    m_st = nxt;
  endtask

  task automatic check_now(input string tag, input int st, input int tm, input int ch);
    chk({tag, ".state"}, 8'(state), 8'(st));
    chk({tag, ".timer"}, 8'(timer), 8'(tm));
    chk({tag, ".cheat"}, 8'(cheat), 8'(ch));
    chk({tag, ".alarms"}, 8'({a3, a2, a1}), 8'(alarms_of(st)));
  endtask

  // One transaction: drive, predict/push, clock, pop/compare.
  task automatic step(input string tag, input bit gi, input bit yi, input bit ri);
    exp_t e;
    g = gi; y = yi; r = ri;
    model_edge(gi, yi, ri);
    e.st = m_st; e.tm = m_tm; e.ch = m_ch;
    q.push_back(e);
    @(posedge clk);
    #1;
    edge_no++;
    e = q.pop_front();
    $display("%s edge=%0d in(gyr)=%b%b%b state=%0d timer=%0d a=%b%b%b cheat=%b exp_state=%0d exp_timer=%0d",
             tag, edge_no, gi, yi, ri, state, timer, a1, a2, a3, cheat, e.st, e.tm);
    check_now(tag, e.st, e.tm, e.ch);
  endtask

  task automatic steps(input string tag, input int n, input bit gi, input bit yi, input bit ri);
    for (int i = 0; i < n; i++) step(tag, gi, yi, ri);
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_st = 0; m_tm = 0; m_ch = 0;
    $display("%s reset asserted state=%0d timer=%0d a=%b%b%b cheat=%b", tag, state, timer, a1, a2, a3, cheat);
    check_now({tag, ".rst"}, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    edge_no = 0;
  endtask

  initial begin
    rst_n = 1'b1;
    g = 1'b0; y = 1'b0; r = 1'b0;
    #2;

    // 1: green run OK -> ATTACK at edge 20 -> OK at edge 30.
    do_reset("t1");
    steps("t1", 30, 1, 0, 0);
    chk("t1.back_to_ok", 8'(state), 8'd0);

    // 2: green 25, yellow 22, then green through RECOVER back to OK.
    do_reset("t2");
    steps("t2", 25, 1, 0, 0);
    steps("t2", 22, 0, 1, 0);
    chk("t2.in_a1", 8'(state), 8'd2);
    steps("t2", 6, 1, 0, 0);
    chk("t2.ok_again", 8'(state), 8'd0);

    // 3: yellow from reset escalates A1 -> A2 -> LOCKDOWN.
    do_reset("t3");
    steps("t3", 91, 0, 1, 0);
    chk("t3.lockdown", 8'(state), 8'd4);
    steps("t3", 3, 0, 1, 0);

    // 4: red from several states, then lockdown exit rules.
    do_reset("t4ok");
    steps("t4ok", 3, 1, 0, 0);
    step("t4ok", 0, 0, 1);
    do_reset("t4at");
    steps("t4at", 21, 1, 0, 0);
    step("t4at", 0, 0, 1);
    do_reset("t4a1");
    step("t4a1", 0, 1, 0);
    step("t4a1", 0, 0, 1);
    do_reset("t4a2");
    steps("t4a2", 31, 0, 1, 0);
    step("t4a2", 0, 0, 1);
    steps("t4lk", 9, 1, 0, 0);
    step("t4lk", 0, 1, 0);
    chk("t4.lock_timer_cleared", 8'(timer), 8'd0);
    steps("t4lk", 10, 1, 0, 0);
    chk("t4.recover", 8'(state), 8'd5);
    step("t4rc", 0, 0, 1);
    chk("t4.rec_to_lock", 8'(state), 8'd4);

    // 5: invalid samples freeze the FSM at timer 7.
    do_reset("t5");
    steps("t5", 7, 1, 0, 0);
    step("t5", 0, 0, 0);
    step("t5", 1, 1, 0);
    step("t5", 1, 1, 1);
    chk("t5.frozen", 8'(timer), 8'd7);
    step("t5", 1, 0, 0);
    chk("t5.resume", 8'(timer), 8'd8);

    // 6: asynchronous reset in the middle of LOCKDOWN.
    do_reset("t6");
    step("t6", 0, 0, 1);
    steps("t6", 4, 1, 0, 0);
    chk("t6.pre_reset_timer", 8'(timer), 8'd4);
    do_reset("t6mid");
    steps("t6", 2, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
